// File: rtl/sp_arb_pkg.sv
// rtl/sp_arb_pkg.sv - shared types, defaults and rotate-priority pick for the serial arbiter
package sp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FRAME_W_DEF = 6;
    localparam int MAX_SRC     = 16;

    // First set request at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic [3:0] pick;
        logic [3:0] idx;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < n) begin
                idx = 4'((int'(ptr) + i) % n);
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// rtl/rr_pick_n.sv - combinational rotate-priority encoder over N_SRC requests
module rr_pick_n
    import sp_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = SRC_W'(rr_pick(MAX_SRC'(req), 4'(ptr), N_SRC));
        any = |req;
    end

endmodule

// File: rtl/s_to_p_rr_arbiter.sv
// rtl/s_to_p_rr_arbiter.sv - round-robin share of one serial-to-parallel converter, frame-locked grants
module s_to_p_rr_arbiter
    import sp_arb_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int SRC_W   = $clog2(N_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   req_valid,
    input  logic [N_SRC-1:0]   req_data,
    output logic [N_SRC-1:0]   req_ready,
    output logic               conv_valid_a,
    output logic               conv_data_a,
    input  logic               conv_ready_a,
    input  logic               conv_valid_b,
    input  logic [FRAME_W-1:0] conv_data_b,
    output logic               out_valid,
    output logic [FRAME_W-1:0] out_data,
    output logic [SRC_W-1:0]   out_src
);

    localparam int CNT_W = $clog2(FRAME_W);

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [FRAME_W-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;

    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic               xfer;
    logic               last_bit;
    logic [SRC_W-1:0]   gnt_next_ptr;

    rr_pick_n #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Serial path: only the granted source talks, and only when the converter takes the bit.
    always_comb begin
        xfer         = (state_q == BUSY) && req_valid[gnt_q] && conv_ready_a;
        last_bit     = xfer && (bit_cnt_q == CNT_W'(FRAME_W - 1));
        conv_valid_a = xfer;
        conv_data_a  = (state_q == BUSY) ? req_data[gnt_q] : 1'b0;
        req_ready    = '0;
        if (xfer) begin
            req_ready[gnt_q] = 1'b1;
        end
        gnt_next_ptr = (gnt_q == SRC_W'(N_SRC - 1)) ? '0 : gnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        bit_cnt_d   = bit_cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        ptr_d     = gnt_next_ptr;
                        state_d   = DRAIN;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Word pulses outside DRAIN belong to nobody and are dropped.
                if (conv_valid_b) begin
                    out_valid_d = 1'b1;
                    out_data_d  = conv_data_b;
                    out_src_d   = gnt_q;
                    if (pick_any) begin
                        gnt_d   = pick_idx;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_s_to_p_rr_arbiter.sv
// tb/tb_s_to_p_rr_arbiter.sv - scoreboard bench for s_to_p_rr_arbiter with a behavioural converter
module tb_s_to_p_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_data;
    logic [3:0] req_ready;
    logic       conv_valid_a;
    logic       conv_data_a;
    logic       conv_ready_a;
    logic       conv_valid_b;
    logic [5:0] conv_data_b;
    logic       out_valid;
    logic [5:0] out_data;
    logic [1:0] out_src;

    logic       model_vb;
    logic       spur;
    logic [5:0] model_sh;
    int         model_cnt;

    int         checks;
    int         errors;
    int         cyc;
    int         pulse_cnt;
    int         last_end;
    bit         chk_bubble;
    bit         in_gap;
    int         gap_src;
    int         gap_at;
    int         gap_left;
    logic [3:0] acc;

    bit         srcq[4][$];
    int         popped[4];
    logic [7:0] exp_q[$];

    s_to_p_rr_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .conv_valid_a (conv_valid_a),
        .conv_data_a  (conv_data_a),
        .conv_ready_a (conv_ready_a),
        .conv_valid_b (conv_valid_b),
        .conv_data_b  (conv_data_b),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign conv_valid_b = model_vb | spur;

    // Converter: LSB-first shift, word pulse the cycle after the sixth accepted bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_vb    <= 1'b0;
            model_sh    <= '0;
            model_cnt   <= 0;
            conv_data_b <= '0;
        end else begin
            model_vb <= 1'b0;
            if (conv_valid_a && conv_ready_a) begin
                model_sh[model_cnt] <= conv_data_a;
                if (model_cnt == 5) begin
                    model_vb    <= 1'b1;
                    conv_data_b <= {conv_data_a, model_sh[4:0]};
                    model_cnt   <= 0;
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Source drivers: each source presents the head of its bit queue.
    initial begin
        req_valid = '0;
        req_data  = '0;
        in_gap    = 1'b0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            in_gap = 1'b0;
            for (int s = 0; s < 4; s++) begin
                if (acc[s] && srcq[s].size() > 0) begin
                    srcq[s].delete(0);
                    popped[s]++;
                end
                if (gap_left > 0 && s == gap_src && popped[s] % 6 == gap_at && srcq[s].size() > 0) begin
                    req_valid[s] = 1'b0;
                    gap_left--;
                    in_gap = 1'b1;
                end else begin
                    req_valid[s] = (srcq[s].size() > 0);
                end
                req_data[s] = (srcq[s].size() > 0) ? srcq[s][0] : 1'b0;
            end
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (!rst_n) begin
            pulse_cnt = 0;
            last_end  = 0;
        end else begin
            if (req_ready != 4'b0) begin
                check_eq("rdy_onehot", 32'($onehot(req_ready)), 32'd1);
                check_eq("rdy_unreq", 32'(req_ready & ~req_valid), 32'd0);
            end
            if (!conv_ready_a) check_eq("cva_not_ready", 32'(conv_valid_a), 32'd0);
            if (in_gap) check_eq("gap_rdy", 32'(req_ready), 32'd0);
            if (conv_valid_a) begin
                if (chk_bubble && pulse_cnt > 0 && pulse_cnt % 6 == 0)
                    check_eq("bubble", 32'(cyc - last_end), 32'd2);
                pulse_cnt++;
                if (pulse_cnt % 6 == 0) last_end = cyc;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", 32'(out_data), 32'(e[5:0]));
                    check_eq("out_src", 32'(out_src), 32'(e[7:6]));
                    check_eq("latency", 32'(cyc - last_end), 32'd2);
                end
            end
        end
    end

    task automatic push_frame(input int s, input logic [5:0] w);
        for (int i = 0; i < 6; i++) srcq[s].push_back(w[i]);
        exp_q.push_back({2'(s), w});
    endtask

    task automatic clear_all();
        for (int s = 0; s < 4; s++) begin
            srcq[s].delete();
            popped[s] = 0;
        end
        exp_q.delete();
        gap_left = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(posedge clk);
        check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_popped(input int s, input int n);
        for (int i = 0; i < 500 && popped[s] < n; i++) @(posedge clk);
        check_eq("popped_timeout", 32'(popped[s] >= n), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] w;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        chk_bubble   = 1'b0;
        spur         = 1'b0;
        conv_ready_a = 1'b1;
        gap_src      = 0;
        gap_at       = 0;
        gap_left     = 0;
        rst_n        = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_src", 32'(out_src), 32'd0);
        check_eq("rst_cva", 32'(conv_valid_a), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        do_reset();

        // 1: single frame from src1, bits 1,0,1,1,0,0
        push_frame(1, 6'b001101);
        wait_done();
        check_eq("t1_pulses", 32'(pulse_cnt), 32'd6);
        check_eq("t1_hold_data", 32'(out_data), 32'h0d);
        check_eq("t1_hold_src", 32'(out_src), 32'd1);

        // stray converter word while idle must not produce output
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 2: all sources continuous, grants 0,1,2,3,0 with one bubble between frames
        do_reset();
        chk_bubble = 1'b1;
        for (int s = 0; s < 4; s++) begin
            w = 6'($urandom);
            push_frame(s, w);
        end
        w = 6'($urandom);
        push_frame(0, w);
        wait_done();
        check_eq("t2_pulses", 32'(pulse_cnt), 32'd30);
        chk_bubble = 1'b0;

        // 3: granted src2 stalls 3 cycles after bit 2 while src3 waits
        do_reset();
        gap_src  = 2;
        gap_at   = 3;
        gap_left = 3;
        push_frame(2, 6'b110010);
        push_frame(3, 6'b011011);
        wait_done();
        check_eq("t3_gap_used", 32'(gap_left), 32'd0);
        check_eq("t3_pulses", 32'(pulse_cnt), 32'd12);

        // 4: converter not ready just after reset
        rst_n = 1'b0;
        clear_all();
        conv_ready_a = 1'b0;
        push_frame(0, 6'b101011);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 conv_ready_a = 1'b1;
        wait_done();
        check_eq("t4_pulses", 32'(pulse_cnt), 32'd6);

        // 5: async reset at bit 3, then src1 and src3 requesting, ptr must restart at 0
        do_reset();
        push_frame(1, 6'b101101);
        wait_done();
        push_frame(2, 6'b111111);
        wait_popped(2, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_out_data", 32'(out_data), 32'd0);
        check_eq("t5_out_src", 32'(out_src), 32'd0);
        check_eq("t5_cva", 32'(conv_valid_a), 32'd0);
        check_eq("t5_req_ready", 32'(req_ready), 32'd0);
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_frame(1, 6'b010110);
        push_frame(3, 6'b100111);
        wait_done();
        check_eq("t5_hold_src", 32'(out_src), 32'd3);
        check_eq("t5_hold_data", 32'(out_data), 32'h27);

        // 6: lone requester src0 re-granted for three frames
        do_reset();
        chk_bubble = 1'b1;
        for (int f = 0; f < 3; f++) begin
            w = 6'($urandom);
            push_frame(0, w);
        end
        wait_done();
        check_eq("t6_pulses", 32'(pulse_cnt), 32'd18);
        chk_bubble = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
